// File: rtl/sevenseg_scan_ctrl.sv
// ============================================================================
// sevenseg_scan_ctrl : multiplexed seven-segment scan controller with
// double-buffered display contents. Optional macro: SEVENSEG_RAW_MODE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 12500,
  parameter int BLANK_CYC  = 64,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [BRIGHT_W-1:0]     i_bright,
`ifdef SEVENSEG_RAW_MODE_EN
  input  logic                    i_raw_mode,
  input  logic [7*NUM_DIGITS-1:0] i_raw_seg,
`endif
  input  logic                    i_load,
  output logic                    o_pending,
  output logic                    o_frame_done,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp
);

  localparam int C_IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int C_PRESC_W = $clog2(SCAN_DIV);

  localparam logic [C_PRESC_W-1:0] C_PRESC_LAST = C_PRESC_W'(SCAN_DIV - 1);
  localparam logic [C_PRESC_W-1:0] C_BLANK_END  = C_PRESC_W'(BLANK_CYC);
  localparam logic [C_IDX_W-1:0]   C_IDX_LAST   = C_IDX_W'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   en;
    logic [NUM_DIGITS-1:0]   dp;
    logic [BRIGHT_W-1:0]     bright;
`ifdef SEVENSEG_RAW_MODE_EN
    logic                    raw_mode;
    logic [7*NUM_DIGITS-1:0] raw_seg;
`endif
  } disp_t;

  // Active-high {A..G} glyphs for hex digits
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1111011;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b0011111;
      4'hC:    seg = 7'b1001110;
      4'hD:    seg = 7'b0111101;
      4'hE:    seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
    return seg;
  endfunction

  logic [C_PRESC_W-1:0]  presc_q, presc_d;
  logic [C_IDX_W-1:0]    idx_q, idx_d;
  logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
  disp_t                 act_q, act_d;
  disp_t                 pend_q, pend_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  disp_t      w_in;
  logic       w_slot_end;
  logic       w_frame_end;
  logic [3:0] w_nib;
  logic       w_en_sel;
  logic       w_dp_sel;
  logic       w_pwm_on;
  logic       w_lit;
  logic [6:0] w_glyph;
`ifdef SEVENSEG_RAW_MODE_EN
  logic [6:0] w_raw_sel;
`endif

  always_comb begin
    w_in        = '0;
    w_in.value  = i_value;
    w_in.en     = i_digit_en;
    w_in.dp     = i_dp;
    w_in.bright = i_bright;
`ifdef SEVENSEG_RAW_MODE_EN
    w_in.raw_mode = i_raw_mode;
    w_in.raw_seg  = i_raw_seg;
`endif
  end

  // Scan timing: prescaler, digit index and free-running PWM counter
  always_comb begin
    w_slot_end  = (presc_q == C_PRESC_LAST);
    w_frame_end = w_slot_end && (idx_q == C_IDX_LAST);
    presc_d     = w_slot_end ? '0 : presc_q + C_PRESC_W'(1);
    idx_d       = idx_q;
    if (w_slot_end) begin
      idx_d = w_frame_end ? '0 : idx_q + C_IDX_W'(1);
    end
    pwm_d = pwm_q + BRIGHT_W'(1);
  end

  // A load coinciding with the boundary wins over an older pending buffer
  always_comb begin
    act_d     = act_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (w_frame_end) begin
      if (i_load) begin
        act_d = w_in;
      end else if (pending_q) begin
        act_d = pend_q;
      end
      pending_d = 1'b0;
    end else if (i_load) begin
      pend_d    = w_in;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    w_nib    = '0;
    w_en_sel = 1'b0;
    w_dp_sel = 1'b0;
`ifdef SEVENSEG_RAW_MODE_EN
    w_raw_sel = '0;
`endif
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_q == C_IDX_W'(d)) begin
        w_nib    = act_q.value[4*d +: 4];
        w_en_sel = act_q.en[d];
        w_dp_sel = act_q.dp[d];
`ifdef SEVENSEG_RAW_MODE_EN
        w_raw_sel = act_q.raw_seg[7*d +: 7];
`endif
      end
    end
  end

  always_comb begin
    w_pwm_on = (pwm_q <= act_q.bright);
    w_lit    = (presc_q >= C_BLANK_END) && w_en_sel && w_pwm_on;
`ifdef SEVENSEG_RAW_MODE_EN
    w_glyph  = act_q.raw_mode ? w_raw_sel : hex_to_seg(w_nib);
`else
    w_glyph  = hex_to_seg(w_nib);
`endif

    frame_done_d = w_frame_end;
    an_d         = '1;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      an_d[d] = !(w_lit && (idx_q == C_IDX_W'(d)));
    end
    if (w_lit) begin
      seg_d = ~w_glyph;
      dp_d  = ~w_dp_sel;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      act_q        <= '0;
      pend_q       <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign o_pending    = pending_q;
  assign o_frame_done = frame_done_q;
  assign o_an         = an_q;
  assign o_seg        = seg_q;
  assign o_dp         = dp_q;

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_scan_ctrl.sv
// ============================================================================
// tb_sevenseg_scan_ctrl : directed bench with a queued reference scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sevenseg_scan_ctrl;

  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] i_value;
  logic [3:0]  i_digit_en;
  logic [3:0]  i_dp;
  logic [1:0]  i_bright;
  logic        i_load;
  logic        o_pending;
  logic        o_frame_done;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
`ifdef SEVENSEG_RAW_MODE_EN
  logic        i_raw_mode;
  logic [27:0] i_raw_seg;
`endif

  sevenseg_scan_ctrl #(
    .NUM_DIGITS(ND),
    .SCAN_DIV  (8),
    .BLANK_CYC (2),
    .BRIGHT_W  (2)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_value     (i_value),
    .i_digit_en  (i_digit_en),
    .i_dp        (i_dp),
    .i_bright    (i_bright),
`ifdef SEVENSEG_RAW_MODE_EN
    .i_raw_mode  (i_raw_mode),
    .i_raw_seg   (i_raw_seg),
`endif
    .i_load      (i_load),
    .o_pending   (o_pending),
    .o_frame_done(o_frame_done),
    .o_an        (o_an),
    .o_seg       (o_seg),
    .o_dp        (o_dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pending;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  int          m_presc, m_idx, m_pwm;
  logic [15:0] m_val,  p_val;
  logic [3:0]  m_en,   p_en;
  logic [3:0]  m_dp,   p_dp;
  logic [1:0]  m_br,   p_br;
  logic        m_pending;

  // Window counters
  int c_an_e, c_an_f, c_seg_a, c_seg_f, c_pend, c_fd_first;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    return t[n];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_presc = 0; m_idx = 0; m_pwm = 0;
    m_val = '0; m_en = '0; m_dp = '0; m_br = '0;
    p_val = '0; p_en = '0; p_dp = '0; p_br = '0;
    m_pending = 1'b0;
    sb.delete();
  endtask

  // One clock: predict, advance the model, sample the DUT after the edge
  task automatic step();
    exp_t e;
    logic lit, fe;
    logic [3:0] nib;
    nib   = m_val[m_idx*4 +: 4];
    lit   = (m_presc >= 2) && m_en[m_idx] && (m_pwm <= int'(m_br));
    fe    = (m_presc == 7) && (m_idx == 3);
    e.an  = lit ? ~(4'b0001 << m_idx) : 4'hF;
    e.seg = lit ? ~glyph(nib) : 7'h7F;
    e.dp  = lit ? ~m_dp[m_idx] : 1'b1;
    e.fd  = fe;
    if (fe) begin
      if (i_load) begin
        m_val = i_value; m_en = i_digit_en; m_dp = i_dp; m_br = i_bright;
      end else if (m_pending) begin
        m_val = p_val; m_en = p_en; m_dp = p_dp; m_br = p_br;
      end
      m_pending = 1'b0;
    end else if (i_load) begin
      p_val = i_value; p_en = i_digit_en; p_dp = i_dp; p_br = i_bright;
      m_pending = 1'b1;
    end
    e.pending = m_pending;
    sb.push_back(e);
    m_pwm   = (m_pwm + 1) % 4;
    m_idx   = (m_presc == 7) ? (m_idx + 1) % ND : m_idx;
    m_presc = (m_presc + 1) % 8;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("an", 32'(o_an), 32'(e.an));
    chk("seg", 32'(o_seg), 32'(e.seg));
    chk("dp", 32'(o_dp), 32'(e.dp));
    chk("pending", 32'(o_pending), 32'(e.pending));
    chk("frame_done", 32'(o_frame_done), 32'(e.fd));
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] en,
                      input logic [3:0] dp, input logic [1:0] br);
    i_value = v; i_digit_en = en; i_dp = dp; i_bright = br; i_load = 1'b1;
    step();
    i_load = 1'b0;
  endtask

  task automatic wait_fd(input int budget);
    int k;
    k = 0;
    while (!o_frame_done && k < budget) begin
      step();
      k++;
    end
    chk("frame_done_reached", 32'(o_frame_done), 32'd1);
  endtask

  task automatic window(input int n);
    c_an_e = 0; c_an_f = 0; c_seg_a = 0; c_seg_f = 0; c_pend = 0; c_fd_first = -1;
    for (int k = 1; k <= n; k++) begin
      step();
      if (o_an == 4'b1110)  c_an_e++;
      if (o_an == 4'hF)     c_an_f++;
      if (o_seg == 7'h08)   c_seg_a++;
      if (o_seg == 7'h38)   c_seg_f++;
      if (o_pending)        c_pend++;
      if (o_frame_done && c_fd_first < 0) c_fd_first = k;
    end
  endtask

  initial begin
    int fd_cnt;
    int k;
    rstn = 1'b0; i_value = '0; i_digit_en = '0; i_dp = '0; i_bright = '0; i_load = 1'b0;
`ifdef SEVENSEG_RAW_MODE_EN
    i_raw_mode = 1'b0; i_raw_seg = '0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(o_an), 32'hF);
    chk("rst_seg", 32'(o_seg), 32'h7F);
    chk("rst_dp", 32'(o_dp), 32'd1);
    chk("rst_pending", 32'(o_pending), 32'd0);
    chk("rst_fd", 32'(o_frame_done), 32'd0);
    rstn = 1'b1;

    // Blank display, frame pulses every 32 cycles
    fd_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (o_frame_done) fd_cnt++;
    end
    chk("idle_fd_count", 32'(fd_cnt), 32'd3);

    // Mid-frame load, then overwrite while pending
    load(16'h1234, 4'hF, 4'h0, 2'd3);
    chk("pending_set", 32'(o_pending), 32'd1);
    step(); step();
    load(16'h3A91, 4'hF, 4'b0100, 2'd3);
    chk("pending_hold", 32'(o_pending), 32'd1);
    chk("old_blank_persists", 32'(o_an), 32'hF);
    wait_fd(64);
    chk("pending_falls_on_fd", 32'(o_pending), 32'd0);
    window(32);
    chk("slot0_an_cycles", 32'(c_an_e), 32'd6);
    chk("blank_cycles", 32'(c_an_f), 32'd8);
    chk("digitA_cycles", 32'(c_seg_a), 32'd6);

    // Brightness 0 and 1
    load(16'h3A91, 4'hF, 4'h0, 2'd0);
    wait_fd(64);
    window(32);
    chk("bright0_lit", 32'(32 - c_an_f), 32'd4);
    load(16'h3A91, 4'hF, 4'h0, 2'd1);
    wait_fd(64);
    window(32);
    chk("bright1_lit", 32'(32 - c_an_f), 32'd8);

    // Load coincident with a frame end
    k = 0;
    while (!(m_presc == 7 && m_idx == 3) && k < 40) begin
      step();
      k++;
    end
    chk("reach_frame_end", 32'(k < 40), 32'd1);
    load(16'hBEEF, 4'h1, 4'h0, 2'd3);
    chk("coincident_pending", 32'(o_pending), 32'd0);
    chk("coincident_fd", 32'(o_frame_done), 32'd1);
    window(32);
    chk("coincident_pend_never", 32'(c_pend), 32'd0);
    chk("coincident_slot0", 32'(c_an_e), 32'd6);
    chk("coincident_glyphF", 32'(c_seg_f), 32'd6);

    // Asynchronous reset mid-slot
    repeat (4) step();
    chk("pre_reset_lit", 32'(o_an), 32'hE);
    rstn = 1'b0;
    #1;
    chk("async_an", 32'(o_an), 32'hF);
    chk("async_seg", 32'(o_seg), 32'h7F);
    chk("async_dp", 32'(o_dp), 32'd1);
    chk("async_pending", 32'(o_pending), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    window(32);
    chk("post_reset_blank", 32'(c_an_f), 32'd32);
    chk("post_reset_fd_at", 32'(c_fd_first), 32'd32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
